ysyx_23060191_wbc: RTL and testbench
====================================

YSYX_23060191_WBC -- requirements
Module: ysyx_23060191_WBC

Interface
REQ-001 SHALL have parameter CPU_WIDTH, default 32, data width of the EXU result, the LSU result and the register-file write data.
REQ-002 SHALL have parameter REG_AW, default 5, register-file address width.
REQ-003 SHALL have parameter STARVE_MAX, default 3, number of consecutive EXU losses before EXU takes priority; legal range 1..15.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port flush  in  1  drop any writeback offered this cycle.
REQ-007 SHALL have ports exu_valid in 1, exu_ready out 1, exu_rd in REG_AW, exu_res in CPU_WIDTH: EXU writeback request.
REQ-008 SHALL have ports lsu_valid in 1, lsu_ready out 1, lsu_rd in REG_AW, lsu_res in CPU_WIDTH: LSU load-result request.
REQ-009 SHALL have ports rf_wen out 1, rf_waddr out REG_AW, rf_wdata out CPU_WIDTH: single register-file write port.
REQ-010 SHALL have ports commit_valid out 1, commit_src out 1 (0=EXU, 1=LSU): one-cycle retire pulse.
REQ-011 SHALL have port commit_cnt  out 32  retired-instruction count.
REQ-012 SHALL have ports fwd_valid out 1, fwd_rd out REG_AW, fwd_data out CPU_WIDTH: bypass of the in-flight write.

Function
REQ-013 SHALL accept a request only on a handshake (valid && ready); at most one handshake per cycle.
REQ-014 SHALL hold exu_ready and lsu_ready low while flush=1 or rst_n=0; flush has priority over every grant.
REQ-015 SHALL drive exu_ready and lsu_ready combinationally from this cycle's valids and the priority state, with no dependency on the ready signals.
REQ-016 SHALL keep a 2-state priority FSM: LSU_PRI (reset state) and EXU_PRI.
REQ-017 In LSU_PRI, SHALL grant LSU when lsu_valid=1; otherwise SHALL grant EXU when exu_valid=1.
REQ-018 In EXU_PRI, SHALL grant EXU when exu_valid=1; otherwise SHALL grant LSU when lsu_valid=1.
REQ-019 SHALL keep a 4-bit wait counter that increments (saturating at STARVE_MAX) each cycle exu_valid=1 and EXU is not granted.
REQ-020 SHALL clear the wait counter on an EXU handshake, or in any cycle with exu_valid=0.
REQ-021 SHALL move LSU_PRI->EXU_PRI on the edge where the counter's next value equals STARVE_MAX.
REQ-022 SHALL move EXU_PRI->LSU_PRI on the edge following an EXU handshake; otherwise SHALL stay in EXU_PRI.
REQ-023 SHALL register a handshake: on the next cycle, for exactly one cycle, rf_waddr/rf_wdata = granted rd/result and commit_valid=1 with commit_src set.
REQ-024 SHALL set rf_wen = commit_valid && (rf_waddr != 0); an x0 write SHALL still commit but SHALL NOT write.
REQ-025 SHALL drive commit_valid=0 and rf_wen=0 in any cycle not preceded by a handshake; rf_waddr/rf_wdata hold their last value.
REQ-026 SHALL increment commit_cnt by 1 on every commit_valid cycle, wrapping 0xFFFFFFFF->0.
REQ-027 SHALL fix latency at handshake to rf write = 1 cycle and sustain a throughput of 1 write per cycle.

Reset
REQ-028 While rst_n=0 at a rising edge, SHALL set rf_wen=0, rf_waddr=0, rf_wdata=0, commit_valid=0, commit_src=0, commit_cnt=0, FSM=LSU_PRI, wait counter=0 and all fwd_* to 0.
REQ-029 SHALL discard a handshake captured in the same cycle reset is asserted: no commit, rf_wen=0 after reset.

Configuration
REQ-030 SHALL use the macro YSYX_23060191_WBC_BYPASS_EN.
REQ-031 With YSYX_23060191_WBC_BYPASS_EN defined, SHALL drive fwd_valid=rf_wen, fwd_rd=rf_waddr and fwd_data=rf_wdata, all combinational from the write registers.
REQ-032 Without YSYX_23060191_WBC_BYPASS_EN, SHALL keep the fwd_* ports and tie them to constant 0; all other behaviour SHALL be identical.

Verification
REQ-033 SHALL cover single EXU: exu_valid=1, rd=5, res=0x1234 -> exu_ready=1 same cycle; next cycle rf_wen=1, waddr=5, wdata=0x1234, commit_src=0, commit_cnt=1.
REQ-034 SHALL cover the simultaneous-request case: both valid, lsu rd=3/0xAA, exu rd=4/0xBB, held asserted -> LSU granted first; with STARVE_MAX=3, after 3 LSU wins EXU is granted on the 4th cycle; the cycle after, the FSM returns to LSU_PRI.
REQ-035 SHALL cover x0 suppression: lsu rd=0, res=0xFF -> commit_valid=1, commit_src=1, rf_wen=0, commit_cnt increments.
REQ-036 SHALL cover flush: both valid with flush=1 -> both readys 0; next cycle commit_valid=0, counter unchanged.
REQ-037 SHALL cover reset mid-stream: back-to-back EXU writes with rst_n low for one edge -> all outputs 0, commit_cnt=0, FSM=LSU_PRI.
REQ-038 SHALL cover the bypass build: macro defined, EXU rd=7/0x55 -> fwd_valid=1, fwd_rd=7, fwd_data=0x55 on the rf_wen cycle; macro undefined -> fwd_* stay 0.

Source files
------------

// File: rtl/ysyx_23060191_wbc.sv
// Writeback controller: arbitrates EXU/LSU results onto one register-file write port with starvation-bounded priority.
// Optional macro YSYX_23060191_WBC_BYPASS_EN exposes the registered write on the fwd_* bypass ports.
module ysyx_23060191_wbc #(
    parameter int CPU_WIDTH  = 32,
    parameter int REG_AW     = 5,
    parameter int STARVE_MAX = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 exu_valid,
    output logic                 exu_ready,
    input  logic [REG_AW-1:0]    exu_rd,
    input  logic [CPU_WIDTH-1:0] exu_res,
    input  logic                 lsu_valid,
    output logic                 lsu_ready,
    input  logic [REG_AW-1:0]    lsu_rd,
    input  logic [CPU_WIDTH-1:0] lsu_res,
    output logic                 rf_wen,
    output logic [REG_AW-1:0]    rf_waddr,
    output logic [CPU_WIDTH-1:0] rf_wdata,
    output logic                 commit_valid,
    output logic                 commit_src,
    output logic [31:0]          commit_cnt,
    output logic                 fwd_valid,
    output logic [REG_AW-1:0]    fwd_rd,
    output logic [CPU_WIDTH-1:0] fwd_data
);

    typedef enum logic {LSU_PRI = 1'b0, EXU_PRI = 1'b1} pri_e;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        logic [3:0] r;
        if (v >= STARVE_LIM) begin
            r = STARVE_LIM;
        end else begin
            r = v + 4'd1;
        end
        return r;
    endfunction

    pri_e                 state_r;
    logic [3:0]           wait_r;
    logic [3:0]           wait_nxt_s;
    logic                 grant_exu_s;
    logic                 grant_lsu_s;
    logic                 hs_s;
    logic [REG_AW-1:0]    sel_rd_s;
    logic [CPU_WIDTH-1:0] sel_res_s;
    logic                 wen_r;
    logic [REG_AW-1:0]    waddr_r;
    logic [CPU_WIDTH-1:0] wdata_r;
    logic                 cvalid_r;
    logic                 csrc_r;
    logic [31:0]          ccnt_r;

    // Grant selection: ready is the grant itself, so a grant always implies a handshake.
    always_comb begin
        grant_exu_s = 1'b0;
        grant_lsu_s = 1'b0;
        if (!rst_n || flush) begin
            grant_exu_s = 1'b0;
            grant_lsu_s = 1'b0;
        end else if (state_r == EXU_PRI) begin
            grant_exu_s = exu_valid;
            grant_lsu_s = lsu_valid && !exu_valid;
        end else begin
            grant_lsu_s = lsu_valid;
            grant_exu_s = exu_valid && !lsu_valid;
        end
    end

    // Starvation counter next value and the winning request's payload.
    always_comb begin
        wait_nxt_s = 4'd0;
        sel_rd_s   = exu_rd;
        sel_res_s  = exu_res;
        if (exu_valid && !grant_exu_s) begin
            wait_nxt_s = sat_inc(wait_r);
        end else begin
            wait_nxt_s = 4'd0;
        end
        if (grant_lsu_s) begin
            sel_rd_s  = lsu_rd;
            sel_res_s = lsu_res;
        end else begin
            sel_rd_s  = exu_rd;
            sel_res_s = exu_res;
        end
    end

    assign hs_s      = grant_exu_s || grant_lsu_s;
    assign exu_ready = grant_exu_s;
    assign lsu_ready = grant_lsu_s;

    // Priority FSM, starvation counter and registered writeback/commit outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= LSU_PRI;
            wait_r   <= 4'd0;
            wen_r    <= 1'b0;
            waddr_r  <= {REG_AW{1'b0}};
            wdata_r  <= {CPU_WIDTH{1'b0}};
            cvalid_r <= 1'b0;
            csrc_r   <= 1'b0;
            ccnt_r   <= 32'd0;
        end else begin
            wait_r <= wait_nxt_s;
            case (state_r)
                LSU_PRI: state_r <= (wait_nxt_s == STARVE_LIM) ? EXU_PRI : LSU_PRI;
                EXU_PRI: state_r <= grant_exu_s ? LSU_PRI : EXU_PRI;
                default: state_r <= LSU_PRI;
            endcase
            cvalid_r <= hs_s;
            wen_r    <= hs_s && (sel_rd_s != {REG_AW{1'b0}});
            ccnt_r   <= ccnt_r + {31'd0, hs_s};
            if (hs_s) begin
                waddr_r <= sel_rd_s;
                wdata_r <= sel_res_s;
                csrc_r  <= grant_lsu_s;
            end else begin
                waddr_r <= waddr_r;
                wdata_r <= wdata_r;
                csrc_r  <= csrc_r;
            end
        end
    end

    assign rf_wen       = wen_r;
    assign rf_waddr     = waddr_r;
    assign rf_wdata     = wdata_r;
    assign commit_valid = cvalid_r;
    assign commit_src   = csrc_r;
    assign commit_cnt   = ccnt_r;

`ifdef YSYX_23060191_WBC_BYPASS_EN
    assign fwd_valid = wen_r;
    assign fwd_rd    = waddr_r;
    assign fwd_data  = wdata_r;
`else
    assign fwd_valid = 1'b0;
    assign fwd_rd    = {REG_AW{1'b0}};
    assign fwd_data  = {CPU_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_ysyx_23060191_wbc.sv
// Directed self-checking bench for ysyx_23060191_wbc (default parameters); bypass expectations follow
// whether YSYX_23060191_WBC_BYPASS_EN is defined.
module tb_ysyx_23060191_wbc;

`ifdef YSYX_23060191_WBC_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, flush;
    logic        exu_valid, exu_ready, lsu_valid, lsu_ready;
    logic [4:0]  exu_rd, lsu_rd, rf_waddr, fwd_rd;
    logic [31:0] exu_res, lsu_res, rf_wdata, fwd_data, commit_cnt;
    logic        rf_wen, commit_valid, commit_src, fwd_valid;

    int checks   = 0;
    int failures = 0;

    ysyx_23060191_wbc dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_res(exu_res),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_res(lsu_res),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .commit_valid(commit_valid), .commit_src(commit_src), .commit_cnt(commit_cnt),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ev, input logic [4:0] erd, input logic [31:0] eres,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] lres);
        exu_valid = ev; exu_rd = erd; exu_res = eres;
        lsu_valid = lv; lsu_rd = lrd; lsu_res = lres;
        #1;
    endtask

    task automatic chk_rdy(input string tag, input logic er, input logic lr);
        chk({tag, "_exu_ready"}, {31'd0, exu_ready}, {31'd0, er});
        chk({tag, "_lsu_ready"}, {31'd0, lsu_ready}, {31'd0, lr});
    endtask

    task automatic chk_wb(input string tag, input logic cv, input logic src, input logic wen,
                          input logic [4:0] wa, input logic [31:0] wd, input logic [31:0] cnt);
        chk({tag, "_commit_valid"}, {31'd0, commit_valid}, {31'd0, cv});
        chk({tag, "_commit_src"}, {31'd0, commit_src}, {31'd0, src});
        chk({tag, "_rf_wen"}, {31'd0, rf_wen}, {31'd0, wen});
        chk({tag, "_rf_waddr"}, {27'd0, rf_waddr}, {27'd0, wa});
        chk({tag, "_rf_wdata"}, rf_wdata, wd);
        chk({tag, "_commit_cnt"}, commit_cnt, cnt);
        chk({tag, "_fwd_valid"}, {31'd0, fwd_valid}, {31'd0, BYP & wen});
        chk({tag, "_fwd_rd"}, {27'd0, fwd_rd}, BYP ? {27'd0, wa} : 32'd0);
        chk({tag, "_fwd_data"}, fwd_data, BYP ? wd : 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick(); tick();
        chk_wb("reset", 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        drive(1'b1, 5'd5, 32'h1234, 1'b1, 5'd6, 32'h99);
        chk_rdy("in_reset", 1'b0, 1'b0);
        tick();
        chk_wb("reset_drop", 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);

        // Single EXU write
        rst_n = 1'b1;
        drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
        chk_rdy("exu_single", 1'b1, 1'b0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk_wb("exu_single", 1'b1, 1'b0, 1'b1, 5'd5, 32'h1234, 32'd1);
        tick();
        chk_wb("idle_hold", 1'b0, 1'b0, 1'b0, 5'd5, 32'h1234, 32'd1);

        // Both requesting: three LSU wins, then EXU, then back to LSU priority
        drive(1'b1, 5'd4, 32'hBB, 1'b1, 5'd3, 32'hAA);
        chk_rdy("both_1", 1'b0, 1'b1);
        tick();
        chk_wb("both_1", 1'b1, 1'b1, 1'b1, 5'd3, 32'hAA, 32'd2);
        chk_rdy("both_2", 1'b0, 1'b1);
        tick();
        chk_wb("both_2", 1'b1, 1'b1, 1'b1, 5'd3, 32'hAA, 32'd3);
        chk_rdy("both_3", 1'b0, 1'b1);
        tick();
        chk_wb("both_3", 1'b1, 1'b1, 1'b1, 5'd3, 32'hAA, 32'd4);
        chk_rdy("both_4", 1'b1, 1'b0);
        tick();
        chk_wb("both_4", 1'b1, 1'b0, 1'b1, 5'd4, 32'hBB, 32'd5);
        chk_rdy("both_5", 1'b0, 1'b1);

        // x0 load: commits without writing
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFF);
        chk_rdy("x0", 1'b0, 1'b1);
        tick();
        chk_wb("x0", 1'b1, 1'b1, 1'b0, 5'd0, 32'hFF, 32'd6);

        // Flush blocks both requests
        flush = 1'b1;
        drive(1'b1, 5'd4, 32'hBB, 1'b1, 5'd3, 32'hAA);
        chk_rdy("flush", 1'b0, 1'b0);
        tick();
        chk_wb("flush", 1'b0, 1'b1, 1'b0, 5'd0, 32'hFF, 32'd6);
        flush = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();

        // Back-to-back EXU writes interrupted by a one-edge reset
        drive(1'b1, 5'd9, 32'h11, 1'b0, 5'd0, 32'd0);
        chk_rdy("b2b_1", 1'b1, 1'b0);
        tick();
        chk_wb("b2b_1", 1'b1, 1'b0, 1'b1, 5'd9, 32'h11, 32'd7);
        rst_n = 1'b0;
        drive(1'b1, 5'd10, 32'h22, 1'b0, 5'd0, 32'd0);
        chk_rdy("b2b_rst", 1'b0, 1'b0);
        tick();
        chk_wb("mid_reset", 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        rst_n = 1'b1;
        drive(1'b1, 5'd4, 32'hBB, 1'b1, 5'd3, 32'hAA);
        chk_rdy("post_reset_pri", 1'b0, 1'b1);

        // Bypass view of an EXU write
        drive(1'b1, 5'd7, 32'h55, 1'b0, 5'd0, 32'd0);
        chk_rdy("bypass", 1'b1, 1'b0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk_wb("bypass", 1'b1, 1'b0, 1'b1, 5'd7, 32'h55, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
